prog_clock_divider: RTL and testbench
=====================================

# prog_clock_divider

Runtime-programmable integer clock divider producing a 50%-duty `out_clock` for any divisor N in 2..2^WIDTH-1, odd or even, plus single-cycle rise/fall enable ticks in the `clock` domain. It replaces the fixed-ratio dividers: downstream logic uses `out_clock`, or preferably `rise_tick` as a clock enable. The divisor is loaded through a valid/ready port and applied only at a period boundary, so no short or long output pulses occur on reconfiguration.

## Interface
- WIDTH, 16, divisor width in bits
- DEFAULT_DIV, 2, divisor in effect after reset (2..2^WIDTH-1)
- clock  in  1  source clock; all logic on posedge except the odd-N half-cycle register (negedge)
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run request; sampled at period boundaries
- div_value  in  WIDTH  requested divisor N
- div_valid  in  1  div_value is valid
- div_ready  out  1  pending-divisor slot empty
- cfg_err  out  1  one-cycle pulse: accepted divisor was 0 or 1, clamped to 2
- out_clock  out  1  divided clock, 50% duty
- rise_tick  out  1  one-cycle pulse on the cycle out_clock's period starts
- fall_tick  out  1  one-cycle pulse on the last cycle of the high phase (posedge-domain view)

## Operation
- Registers: `count` (WIDTH), `div_cur`, `div_pend`, `pend_full`, `pos_q`, `neg_q`, `running`.
- Terms: N = div_cur, H = ceil(N/2), boundary = (count == N-1), or idle with enable=1.
- Running: count increments each posedge and wraps N-1 -> 0. pos_q = 1 exactly in cycles where count is in [0, H-1].
- Even N: out_clock = pos_q, high for N/2 cycles.
- Odd N: neg_q samples pos_q on negedge. out_clock = pos_q & neg_q, high for N/2 cycles (H-0.5).
- rise_tick = running & count==0. fall_tick = running & count==H-1.
- Handshake: transfer when div_valid & div_ready. div_ready = ~pend_full. The transferred value goes to div_pend and pend_full is set. div_value is held by the source only until transfer.
- Clamp: a value of 0 or 1 is stored as 2, with cfg_err pulsed in the transfer cycle +1.
- Reload: at a boundary with pend_full, div_cur <= div_pend, pend_full clears, and the next period uses the new N.
- Transfer and reload in the same cycle: the reload takes the old pending value. The new value fills the slot, and div_ready stays low.
- States: IDLE (running=0, count=0, pos_q=0) and RUN.
  - IDLE -> RUN on the first posedge with enable=1. That cycle has count=0 and pos_q=1.
  - RUN -> IDLE at a boundary with enable=0. The current period always completes, so there is no truncated pulse.
- Reload is also applied in IDLE, so a pending divisor takes effect at the next start.

## Timing
- Reset values: count=0, div_cur=DEFAULT_DIV, pend_full=0, div_ready=1, pos_q=neg_q=0, out_clock=0, rise_tick=fall_tick=0, cfg_err=0, IDLE.
- rst asserted mid-period forces all reset values immediately (async). out_clock may be truncated, which is acceptable.
- Latency from enable high in IDLE to out_clock high:
  - 1 posedge for even N.
  - 1.5 clock periods for odd N (negedge of the same cycle).
- Latency from divisor transfer to use: at most the current period remaining + 1 cycle.
- Period of out_clock = exactly N source-clock periods in steady state.
- div_ready drops the cycle after a transfer and rises the cycle after the reload.
- N = 2^WIDTH-1 must not overflow count. Compare to N-1; never compute N+1.

## Structure
- Package `clk_div_pkg`: WIDTH default, DEFAULT_DIV, MIN_DIV=2 constant, and the state enum {IDLE, RUN}.
- Sub-module `div_phase_counter`: count, wrap, H compare, and pos_q/tick generation.
- The top level holds the handshake, pending register, clamp, FSM, and negedge shaper.

## Test plan
- Reset, enable=1, N=2 default -> out_clock toggles every cycle; rise_tick every 2 cycles; first high on the 1st posedge.
- Load N=6 -> high 3 cycles, low 3 cycles; rise_tick every 6; fall_tick when count=2.
- Load N=5 -> measure out_clock high 2.5, low 2.5 clock periods; period 5.
- While running N=4 at count=1, load N=7 -> current period ends at 4 cycles, next period 7. div_ready low from the transfer+1 until the reload+1.
- Load 0 -> cfg_err pulse, divisor 2 used. Back-to-back loads 8 then 3 with div_valid held -> second transfer stalls until the reload; periods are 8 then 3.
- enable dropped at count=1 of N=10 -> the period finishes (8 more cycles), then out_clock=0 in IDLE. Async rst mid-high phase -> out_clock=0 immediately.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and state encoding for the programmable clock divider.
package clk_div_pkg;

   localparam int unsigned WIDTH       = 16;
   localparam int unsigned DEFAULT_DIV = 2;
   localparam int unsigned MIN_DIV     = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/div_phase_counter.sv
// Period counter: wraps at N-1, drives the high-phase flag and rise/fall ticks.
module div_phase_counter #(
   parameter int unsigned WIDTH = clk_div_pkg::WIDTH
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_div_cur,
   input  logic [WIDTH-1:0] i_div_nxt,
   input  logic             i_run_nxt,
   input  logic             i_boundary,
   output logic             o_at_end_c,
   output logic             o_pos_q,
   output logic             o_rise_tick,
   output logic             o_fall_tick
);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_hm1_nxt;

   // Last cycle of the period; compares against N-1 so N = 2^WIDTH-1 never overflows.
   assign o_at_end_c  = (r_count == (i_div_cur - WIDTH'(1)));

   // H-1 = ceil(N/2)-1 = (N-1)>>1, taken from the divisor in force next cycle.
   assign w_hm1_nxt   = (i_div_nxt - WIDTH'(1)) >> 1;
   assign w_count_nxt = (i_run_nxt && !i_boundary) ? (r_count + WIDTH'(1)) : '0;

   // Count, high-phase flag and ticks all registered from the next count value.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_count     <= '0;
         o_pos_q     <= 1'b0;
         o_rise_tick <= 1'b0;
         o_fall_tick <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         o_pos_q     <= i_run_nxt && (w_count_nxt <= w_hm1_nxt);
         o_rise_tick <= i_run_nxt && (w_count_nxt == '0);
         o_fall_tick <= i_run_nxt && (w_count_nxt == w_hm1_nxt);
      end
   end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable 50%-duty clock divider with boundary-aligned divisor reload.
module prog_clock_divider #(
   parameter int unsigned WIDTH       = clk_div_pkg::WIDTH,
   parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_div_value,
   input  logic             i_div_valid,
   output logic             o_div_ready,
   output logic             o_cfg_err,
   output logic             o_out_clock,
   output logic             o_rise_tick,
   output logic             o_fall_tick
);

   import clk_div_pkg::*;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_div_cur;
   logic [WIDTH-1:0] r_div_pend;
   logic [WIDTH-1:0] w_div_cur_nxt;
   logic [WIDTH-1:0] w_div_clamped;
   logic             r_pend_full;
   logic             r_cfg_err;
   logic             r_neg_q;
   logic             w_pos_q;
   logic             w_at_end;
   logic             w_boundary;
   logic             w_run_nxt;
   logic             w_xfer;
   logic             w_reload;

   assign w_xfer        = i_div_valid && !r_pend_full;
   assign w_reload      = w_boundary && r_pend_full;
   assign w_div_clamped = (i_div_value < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : i_div_value;
   assign w_div_cur_nxt = w_reload ? r_div_pend : r_div_cur;
   assign w_run_nxt     = (w_state_nxt == RUN);

   // Next state and period boundary: idle starts on enable, run stops only at period end.
   always_comb begin
      w_state_nxt = r_state;
      w_boundary  = 1'b0;
      case (r_state)
         IDLE: begin
            w_boundary = i_enable;
            if (i_enable) w_state_nxt = RUN;
         end
         RUN: begin
            w_boundary = w_at_end;
            if (w_at_end && !i_enable) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, active/pending divisor slot and clamp error pulse.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_div_cur   <= WIDTH'(DEFAULT_DIV);
         r_div_pend  <= WIDTH'(DEFAULT_DIV);
         r_pend_full <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_div_cur   <= w_div_cur_nxt;
         r_pend_full <= w_xfer || (r_pend_full && !w_reload);
         r_cfg_err   <= w_xfer && (i_div_value < WIDTH'(MIN_DIV));
         if (w_xfer) r_div_pend <= w_div_clamped;
      end
   end

   // Half-cycle delayed copy of the high phase; trims odd-N high time by half a cycle.
   always_ff @(negedge clock or posedge rst) begin
      if (rst) r_neg_q <= 1'b0;
      else     r_neg_q <= w_pos_q;
   end

   div_phase_counter #(
      .WIDTH (WIDTH)
   ) u_phase (
      .clock       (clock),
      .rst         (rst),
      .i_div_cur   (r_div_cur),
      .i_div_nxt   (w_div_cur_nxt),
      .i_run_nxt   (w_run_nxt),
      .i_boundary  (w_boundary),
      .o_at_end_c  (w_at_end),
      .o_pos_q     (w_pos_q),
      .o_rise_tick (o_rise_tick),
      .o_fall_tick (o_fall_tick)
   );

   assign o_div_ready = !r_pend_full;
   assign o_cfg_err   = r_cfg_err;
   assign o_out_clock = r_div_cur[0] ? (w_pos_q && r_neg_q) : w_pos_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: half-cycle checks against a period-level reference model.
module tb_prog_clock_divider;

   logic        clock = 1'b0;
   logic        rst   = 1'b1;
   logic        i_enable = 1'b0;
   logic [15:0] i_div_value = '0;
   logic        i_div_valid = 1'b0;
   logic        o_div_ready, o_cfg_err, o_out_clock, o_rise_tick, o_fall_tick;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: run flag, position in period, divisor, pending slot
   bit m_run, m_full, m_xfer, m_err;
   int m_p, m_n, m_pend;

   // observed / expected: {out first half, out second half, rise, fall, ready, err}
   logic [5:0] obsv, expv;

   prog_clock_divider #(.WIDTH(16), .DEFAULT_DIV(2)) dut (
      .clock       (clock),
      .rst         (rst),
      .i_enable    (i_enable),
      .i_div_value (i_div_value),
      .i_div_valid (i_div_valid),
      .o_div_ready (o_div_ready),
      .o_cfg_err   (o_cfg_err),
      .o_out_clock (o_out_clock),
      .o_rise_tick (o_rise_tick),
      .o_fall_tick (o_fall_tick)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      m_run = 0; m_p = 0; m_n = 2; m_pend = 2; m_full = 0; m_xfer = 0; m_err = 0;
   endtask

   // One source-clock period of the specified behaviour, given the inputs before the edge.
   task automatic model_step(input bit en, input bit v, input int val);
      bit bnd, rl;
      int nn;
      bnd    = m_run ? (m_p == m_n - 1) : en;
      m_xfer = v && !m_full;
      rl     = bnd && m_full;
      nn     = rl ? m_pend : m_n;
      m_err  = m_xfer && (val < 2);
      if (m_xfer) m_pend = (val < 2) ? 2 : val;
      m_full = m_xfer || (m_full && !rl);
      if (bnd) begin m_run = en; m_p = 0; end
      else if (m_run) m_p++;
      m_n = nn;
   endtask

   // High for N half-cycles: starting at the posedge for even N, at the negedge for odd N.
   function automatic logic [5:0] model_expect();
      int t, k;
      bit hi, lo;
      t  = 2 * m_p;
      k  = m_n % 2;
      hi = m_run && (t >= k) && (t <= k + m_n - 1);
      lo = m_run && (t + 1 >= k) && (t + 1 <= k + m_n - 1);
      return {hi, lo, m_run && (m_p == 0), m_run && (m_p == (m_n + 1) / 2 - 1), !m_full, m_err};
   endfunction

   // Advance one clock (entered and left at negedge+1), sampling both halves of the cycle.
   task automatic cycle(input bit en, input bit v, input logic [15:0] val);
      logic hi, rs, fl, rd, er;
      i_enable = en; i_div_valid = v; i_div_value = val;
      @(posedge clock);
      model_step(en, v, int'(val));
      #1;
      hi = o_out_clock; rs = o_rise_tick; fl = o_fall_tick; rd = o_div_ready; er = o_cfg_err;
      @(negedge clock);
      #1;
      obsv = {hi, o_out_clock, rs, fl, rd, er};
      expv = model_expect();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock); #1;
      n_tests++;
      if ({o_out_clock, o_rise_tick, o_fall_tick, o_div_ready, o_cfg_err} !== 5'b00010) begin
         n_fail++;
         $display("FAIL reset_hold obs=%b exp=00010", {o_out_clock, o_rise_tick, o_fall_tick, o_div_ready, o_cfg_err});
      end
      rst = 1'b0;
      model_reset();
      repeat (3) begin
         cycle(0, 0, 0);
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL reset_idle t=%0t obs=%b exp=%b", $time, obsv, expv); end
      end
   endtask

   task automatic test_default();
      for (int c = 0; c < 10; c++) begin
         cycle(1, 0, 0);
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL default_n2 c=%0d obs=%b exp=%b", c, obsv, expv); end
      end
   endtask

   task automatic test_n6();
      cycle(1, 1, 16'd6);
      n_tests++;
      if (obsv !== expv) begin n_fail++; $display("FAIL n6_load obs=%b exp=%b", obsv, expv); end
      for (int c = 0; c < 20; c++) begin
         cycle(1, 0, 0);
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL n6 c=%0d obs=%b exp=%b", c, obsv, expv); end
      end
   endtask

   task automatic test_n5();
      int last_rise, h;
      logic prev;
      last_rise = -1; h = 0; prev = 1'b0;
      cycle(1, 1, 16'd5);
      n_tests++;
      if (obsv !== expv) begin n_fail++; $display("FAIL n5_load obs=%b exp=%b", obsv, expv); end
      for (int c = 0; c < 24; c++) begin
         cycle(1, 0, 0);
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL n5 c=%0d obs=%b exp=%b", c, obsv, expv); end
         for (int b = 0; b < 2; b++) begin
            logic cur;
            cur = (b == 0) ? obsv[5] : obsv[4];
            if (cur && !prev && c >= 8) begin
               if (last_rise >= 0) begin
                  n_tests++;
                  if (h - last_rise != 10) begin
                     n_fail++;
                     $display("FAIL n5_period obs=%0d half-cycles exp=10", h - last_rise);
                  end
               end
               last_rise = h;
            end
            prev = cur;
            h++;
         end
      end
   endtask

   task automatic test_reload_mid();
      bit found;
      cycle(1, 1, 16'd4);
      n_tests++;
      if (obsv !== expv) begin n_fail++; $display("FAIL mid_load4 obs=%b exp=%b", obsv, expv); end
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (m_run && m_n == 4 && m_p == 1 && !m_full) found = 1;
         else begin
            cycle(1, 0, 0);
            n_tests++;
            if (obsv !== expv) begin n_fail++; $display("FAIL mid_wait obs=%b exp=%b", obsv, expv); end
         end
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL mid_reach_count1 obs=timeout exp=count1"); end
      cycle(1, 1, 16'd7);
      for (int c = 0; c < 22; c++) begin
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL mid_n4_to_n7 c=%0d obs=%b exp=%b", c, obsv, expv); end
         cycle(1, 0, 0);
      end
   endtask

   task automatic test_clamp();
      for (int z = 0; z < 2; z++) begin
         cycle(1, 1, 16'(z));
         for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (obsv !== expv) begin n_fail++; $display("FAIL clamp_%0d c=%0d obs=%b exp=%b", z, c, obsv, expv); end
            cycle(1, 0, 0);
         end
      end
   endtask

   task automatic test_back_to_back();
      int vals[2];
      bit done;
      vals[0] = 8; vals[1] = 3;
      for (int i = 0; i < 2; i++) begin
         done = 0;
         for (int k = 0; k < 40 && !done; k++) begin
            cycle(1, 1, 16'(vals[i]));
            done = m_xfer;
            n_tests++;
            if (obsv !== expv) begin n_fail++; $display("FAIL b2b_load%0d obs=%b exp=%b", vals[i], obsv, expv); end
         end
         n_tests++;
         if (!done) begin n_fail++; $display("FAIL b2b_xfer%0d obs=timeout exp=transfer", vals[i]); end
      end
      for (int c = 0; c < 24; c++) begin
         cycle(1, 0, 0);
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL b2b_run c=%0d obs=%b exp=%b", c, obsv, expv); end
      end
   endtask

   task automatic test_enable_drop();
      bit found;
      cycle(1, 1, 16'd10);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (m_run && m_n == 10 && m_p == 1) found = 1;
         else begin
            cycle(1, 0, 0);
            n_tests++;
            if (obsv !== expv) begin n_fail++; $display("FAIL drop_wait obs=%b exp=%b", obsv, expv); end
         end
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL drop_reach_count1 obs=timeout exp=count1"); end
      for (int c = 0; c < 12; c++) begin
         cycle(0, 0, 0);
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL drop c=%0d obs=%b exp=%b", c, obsv, expv); end
      end
      n_tests++;
      if (o_out_clock !== 1'b0) begin n_fail++; $display("FAIL drop_idle_out obs=%b exp=0", o_out_clock); end
   endtask

   task automatic test_max_div();
      cycle(0, 1, 16'hFFFF);
      for (int c = 0; c < 65535 + 12; c++) begin
         cycle(1, 0, 0);
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL max_div c=%0d obs=%b exp=%b", c, obsv, expv); end
      end
      cycle(1, 1, 16'd3);
      repeat (65535) begin
         if (m_n == 3) break;
         cycle(1, 0, 0);
      end
      n_tests++;
      if (m_n != 3) begin n_fail++; $display("FAIL max_div_exit obs=%0d exp=3", m_n); end
   endtask

   task automatic test_random();
      bit vhold, en;
      logic [15:0] vval;
      vhold = 0; vval = '0;
      for (int c = 0; c < 500; c++) begin
         en = ($urandom_range(0, 9) != 0);
         if (!vhold && $urandom_range(0, 3) == 0) begin
            vhold = 1;
            vval  = 16'($urandom_range(0, 12));
         end
         cycle(en, vhold, vval);
         if (m_xfer) vhold = 0;
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL random c=%0d obs=%b exp=%b", c, obsv, expv); end
      end
   endtask

   task automatic test_async_reset();
      bit found;
      cycle(1, 1, 16'd6);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         cycle(1, 0, 0);
         if (m_run && m_n == 6 && m_p == 1) found = 1;
      end
      n_tests++;
      if (!found || o_out_clock !== 1'b1) begin
         n_fail++; $display("FAIL arst_reach_high obs=%b exp=1", o_out_clock);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({o_out_clock, o_rise_tick, o_fall_tick, o_div_ready, o_cfg_err} !== 5'b00010) begin
         n_fail++;
         $display("FAIL arst_immediate obs=%b exp=00010", {o_out_clock, o_rise_tick, o_fall_tick, o_div_ready, o_cfg_err});
      end
      @(posedge clock);
      @(negedge clock); #1;
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 6; c++) begin
         cycle(1, 0, 0);
         n_tests++;
         if (obsv !== expv) begin n_fail++; $display("FAIL arst_restart c=%0d obs=%b exp=%b", c, obsv, expv); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_default();
      test_n6();
      test_n5();
      test_reload_mid();
      test_clamp();
      test_back_to_back();
      test_enable_drop();
      test_max_div();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
